// File: rtl/spi_frame_rx.sv
// Frame receiver behind the SPI slave: recovers byte strobes from the slave bit counter,
// parses SYNC/ROW/DATA[/CSUM] frames and commits rows. Checksum stage enabled by FRAME_CSUM_EN.
module spi_frame_rx #(
  parameter int          ROWS      = 16,
  parameter int          ROW_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  localparam int         RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int         DW        = 8 * ROW_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    spi_q,
  input  logic          spi_cnt2,
  output logic [7:0]    spi_d,
  output logic          wr_en,
  output logic [RW-1:0] wr_row,
  output logic [DW-1:0] wr_data,
  output logic          frame_err,
  output logic          busy
);

  localparam int             IW       = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(ROW_BYTES - 1);
  localparam logic [8:0]     ROWS_LIM = 9'(ROWS);

`ifdef FRAME_CSUM_EN
  typedef enum logic [1:0] {IDLE, ROW, DATA, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, ROW, DATA} state_t;
`endif

  logic          sync1_q, sync2_q, hist_q;
  logic          byte_stb;
  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] buf_q, buf_d, buf_ins;
  logic          wr_en_q, wr_en_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          last_ok_q, last_ok_d;
  logic [5:0]    err_cnt_q, err_cnt_d;
  logic [7:0]    status_q, status_d;
  logic          do_commit, do_err;
  logic [DW-1:0] commit_data;
`ifdef FRAME_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  // Slave counter bit 2 falls when the counter wraps 7->0, i.e. a byte has just completed.
  assign byte_stb = hist_q & ~sync2_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    last_ok_d   = last_ok_q;
    err_cnt_d   = err_cnt_q;
    do_commit   = 1'b0;
    do_err      = 1'b0;
    commit_data = buf_q;
    buf_ins     = buf_q;
    buf_ins[idx_q*8 +: 8] = spi_q;
`ifdef FRAME_CSUM_EN
    csum_d      = csum_q;
`endif

    if (byte_stb) begin
      case (state_q)
        IDLE: begin
          if (spi_q == SYNC_BYTE) state_d = ROW;
        end
        ROW: begin
          if ({1'b0, spi_q} < ROWS_LIM) begin
            row_d   = spi_q[RW-1:0];
            idx_d   = '0;
            state_d = DATA;
`ifdef FRAME_CSUM_EN
            csum_d  = 8'h00;
`endif
          end else begin
            do_err  = 1'b1;
            state_d = IDLE;
          end
        end
        DATA: begin
          buf_d = buf_ins;
          idx_d = idx_q + IW'(1);
`ifdef FRAME_CSUM_EN
          csum_d = csum_q ^ spi_q;
          if (idx_q == LAST_IDX) state_d = CSUM;
`else
          // Without a checksum the last data byte completes the frame.
          if (idx_q == LAST_IDX) begin
            do_commit   = 1'b1;
            commit_data = buf_ins;
            state_d     = IDLE;
          end
`endif
        end
`ifdef FRAME_CSUM_EN
        CSUM: begin
          if (spi_q == (8'(row_q) ^ csum_q)) do_commit = 1'b1;
          else                               do_err    = 1'b1;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    if (do_commit) begin
      wr_en_d   = 1'b1;
      wr_row_d  = row_q;
      wr_data_d = commit_data;
      last_ok_d = 1'b1;
    end
    if (do_err) begin
      frame_err_d = 1'b1;
      last_ok_d   = 1'b0;
      if (err_cnt_q != 6'h3F) err_cnt_d = err_cnt_q + 6'd1;
    end

    busy_d   = (state_d != IDLE);
    status_d = {busy_d, last_ok_d, err_cnt_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      state_q     <= IDLE;
      row_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      last_ok_q   <= 1'b0;
      err_cnt_q   <= '0;
      status_q    <= 8'h00;
`ifdef FRAME_CSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      sync1_q     <= spi_cnt2;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      state_q     <= state_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      wr_en_q     <= wr_en_d;
      wr_row_q    <= wr_row_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      last_ok_q   <= last_ok_d;
      err_cnt_q   <= err_cnt_d;
      status_q    <= status_d;
`ifdef FRAME_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign spi_d     = status_q;
  assign wr_en     = wr_en_q;
  assign wr_row    = wr_row_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
